// File: rtl/img_proc_frame_ctrl.sv
// img_proc_frame_ctrl
//   Frame sequencer for the Bayer-to-RGB/greyscale pipe. Tracks capture
//   frame/line timing, generates the X/Y pixel coordinates for demosaic,
//   applies latched processing-mode requests only at frame start, and flags
//   malformed frames.
//
// Build option:
//   FRAME_STATS_EN  adds oFRAME_CNT (completed-frame counter) and oLINE_ERR
//                   (sticky mid-line pixel-gap flag).
//
// Ports:
//   iCLK         pixel clock
//   iRST         asynchronous active-low reset
//   iFVAL        frame valid from capture
//   iDVAL        pixel valid from capture
//   iMODE_REQ    one-cycle mode-change request strobe
//   iMODE_SEL    requested mode (0 raw, 1 grey, 2 reserved->0, 3 bypass)
//   iERR_CLR     clears oERR (and oLINE_ERR when present)
//   oX_Cont      column of the pixel presented this cycle
//   oY_Cont      row of the pixel presented this cycle
//   oMODE        mode applied to the current frame
//   oPEND        a mode request is waiting for the next frame start
//   oDVAL        iDVAL gated to in-frame pixels (zero latency)
//   oFRAME_DONE  one-cycle pulse when a complete frame ends
//   oERR         sticky malformed-frame flag
module img_proc_frame_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int CW       = 11
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic          iMODE_REQ,
  input  logic [1:0]    iMODE_SEL,
  input  logic          iERR_CLR,
  output logic [CW-1:0] oX_Cont,
  output logic [CW-1:0] oY_Cont,
  output logic [1:0]    oMODE,
  output logic          oPEND,
  output logic          oDVAL,
  output logic          oFRAME_DONE,
  output logic          oERR
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]   oFRAME_CNT,
  output logic          oLINE_ERR
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

  state_t     state;
  logic       fval_d;
  logic       rise;
  logic       fall;
  logic [1:0] pend_mode;
  logic [1:0] req_mode;
  logic       err_set;

  assign rise     = iFVAL & ~fval_d;
  assign fall     = ~iFVAL & fval_d;
  // Reserved encoding is folded to raw colour at capture time.
  assign req_mode = (iMODE_SEL == 2'd2) ? 2'd0 : iMODE_SEL;
  assign oDVAL    = (state == ACTIVE) & iDVAL;

  always_comb begin
    err_set = 1'b0;
    if (rise) begin
      err_set = (state != IDLE);
    end else begin
      case (state)
        ACTIVE:  err_set = fall;
        DONE:    err_set = iDVAL;
        default: err_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      fval_d      <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oMODE       <= '0;
      pend_mode   <= '0;
      oPEND       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      fval_d      <= iFVAL;
      oFRAME_DONE <= 1'b0;

      if (err_set) begin
        oERR <= 1'b1;
      end else if (iERR_CLR) begin
        oERR <= 1'b0;
      end

      // A rise restarts the frame from any state (glitches included).
      if (rise) begin
        state   <= ACTIVE;
        oX_Cont <= '0;
        oY_Cont <= '0;
        if (oPEND) begin
          oMODE <= pend_mode;
          oPEND <= 1'b0;
        end
      end else begin
        case (state)
          ACTIVE: begin
            if (fall) begin
              state <= IDLE;
            end else if (iDVAL) begin
              if (oX_Cont == X_LAST) begin
                oX_Cont <= '0;
                if (oY_Cont == Y_LAST) begin
                  oY_Cont <= '0;
                  state   <= DONE;
                end else begin
                  oY_Cont <= oY_Cont + CW'(1);
                end
              end else begin
                oX_Cont <= oX_Cont + CW'(1);
              end
            end
          end
          DONE: begin
            if (fall) begin
              oFRAME_DONE <= 1'b1;
              state       <= IDLE;
            end
          end
          default: ;
        endcase
      end

      // Placed after the rise handling so a request coinciding with the
      // rise survives as pending for the following frame.
      if (iMODE_REQ) begin
        pend_mode <= req_mode;
        oPEND     <= 1'b1;
      end
    end
  end

`ifdef FRAME_STATS_EN
  logic [CW:0] gap;
  logic        gap_run;
  logic        gap_hit;

  // Counts consecutive low iDVAL cycles inside a line; the H_ACTIVE-th
  // such cycle flags the line.
  assign gap_run = (state == ACTIVE) & ~rise & ~fall & ~iDVAL & (oX_Cont != '0);
  assign gap_hit = (gap == (CW+1)'(H_ACTIVE - 1));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oFRAME_CNT <= '0;
      oLINE_ERR  <= 1'b0;
      gap        <= '0;
    end else begin
      if (oFRAME_DONE) begin
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
      end
      if (gap_run) begin
        if (!gap_hit) begin
          gap <= gap + (CW+1)'(1);
        end
      end else begin
        gap <= '0;
      end
      if (gap_run && gap_hit) begin
        oLINE_ERR <= 1'b1;
      end else if (iERR_CLR) begin
        oLINE_ERR <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_img_proc_frame_ctrl.sv
module tb_img_proc_frame_ctrl;

  localparam int H  = 12;
  localparam int V  = 6;
  localparam int CW = 11;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iFVAL;
  logic          iDVAL;
  logic          iMODE_REQ;
  logic [1:0]    iMODE_SEL;
  logic          iERR_CLR;
  logic [CW-1:0] oX_Cont;
  logic [CW-1:0] oY_Cont;
  logic [1:0]    oMODE;
  logic          oPEND;
  logic          oDVAL;
  logic          oFRAME_DONE;
  logic          oERR;

  img_proc_frame_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .CW(CW)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iFVAL(iFVAL),
    .iDVAL(iDVAL),
    .iMODE_REQ(iMODE_REQ),
    .iMODE_SEL(iMODE_SEL),
    .iERR_CLR(iERR_CLR),
    .oX_Cont(oX_Cont),
    .oY_Cont(oY_Cont),
    .oMODE(oMODE),
    .oPEND(oPEND),
    .oDVAL(oDVAL),
    .oFRAME_DONE(oFRAME_DONE),
    .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;

  // Reference model: pixel index within the frame plus a few flags.
  int         pix;
  bit         in_act;
  bit         done_st;
  bit         fprev;
  bit         pend_v;
  logic [1:0] pend_sel;
  logic [1:0] exp_mode;
  bit         exp_err;
  bit         exp_fd;
  bit         rq_en;
  bit         gaps_en;

  task automatic model_reset();
    pix = 0; in_act = 0; done_st = 0; fprev = 0; pend_v = 0;
    pend_sel = 2'd0; exp_mode = 2'd0; exp_err = 0; exp_fd = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input bit d);
    chk("dval",  16'(oDVAL), 16'(in_act & d));
    chk("x",     16'(oX_Cont), 16'(pix % H));
    chk("y",     16'(oY_Cont), 16'(pix / H));
    chk("mode",  16'(oMODE), 16'(exp_mode));
    chk("pend",  16'(oPEND), 16'(pend_v));
    chk("err",   16'(oERR), 16'(exp_err));
    chk("fdone", 16'(oFRAME_DONE), 16'(exp_fd));
  endtask

  task automatic step(input bit f, input bit d, input bit rq, input logic [1:0] sel, input bit clr);
    bit rise;
    bit fall;
    bit set;
    iFVAL = f; iDVAL = d; iMODE_REQ = rq; iMODE_SEL = sel; iERR_CLR = clr;
    @(negedge iCLK);
    chk_all(d);
    @(posedge iCLK);
    #1;
    rise = f && !fprev;
    fall = !f && fprev;
    set = 0;
    exp_fd = 0;
    if (rise) begin
      set = in_act || done_st;
      pix = 0; in_act = 1; done_st = 0;
      if (pend_v) begin
        exp_mode = pend_sel;
        pend_v = 0;
      end
    end else if (in_act) begin
      if (fall) begin
        set = 1; in_act = 0;
      end else if (d) begin
        pix++;
        if (pix == H * V) begin
          pix = 0; in_act = 0; done_st = 1;
        end
      end
    end else if (done_st) begin
      if (d) set = 1;
      if (fall) begin
        exp_fd = 1; done_st = 0;
      end
    end
    if (rq) begin
      pend_sel = (sel == 2'd2) ? 2'd0 : sel;
      pend_v = 1;
    end
    if (set) exp_err = 1;
    else if (clr) exp_err = 0;
    fprev = f;
  endtask

  task automatic rstep(input bit f, input bit d);
    if (rq_en)
      step(f, d, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    else
      step(f, d, 1'b0, 2'd0, 1'b0);
  endtask

  // Sends a frame of npix pixels plus extra pixels after completion.
  // req_at: -1 none, 0 at the rise cycle, k on the k-th pixel.
  task automatic run_frame(input int npix, input int extra, input int req_at, input logic [1:0] rsel);
    if (req_at == 0) step(1'b1, 1'b0, 1'b1, rsel, 1'b0);
    else rstep(1'b1, 1'b0);
    for (int i = 0; i < npix; i++) begin
      while (gaps_en && $urandom_range(0, 3) == 0) rstep(1'b1, 1'b0);
      if (req_at == i + 1) step(1'b1, 1'b1, 1'b1, rsel, 1'b0);
      else rstep(1'b1, 1'b1);
    end
    for (int i = 0; i < extra; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    rstep(1'b0, 1'b0);
    rstep(1'b0, 1'b0);
  endtask

  initial begin
    iRST = 1'b0; iFVAL = 0; iDVAL = 0; iMODE_REQ = 0; iMODE_SEL = 0; iERR_CLR = 0;
    rq_en = 0; gaps_en = 0;
    model_reset();
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk_all(1'b0);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;

    // Clean full frame, continuous pixels.
    run_frame(H * V, 0, -1, 2'd0);
    rstep(1'b0, 1'b0);

    // Mid-frame request for greyscale; applied at next frame start.
    run_frame(H * V, 0, 5, 2'd1);
    // Request at the rise: frame uses mode 1, bypass stays pending.
    run_frame(H * V, 0, 0, 2'd3);
    run_frame(H * V, 0, -1, 2'd0);
    // Reserved mode captured as raw colour.
    run_frame(H * V, 0, 3, 2'd2);
    run_frame(H * V, 0, -1, 2'd0);

    // Short frame, then clear, then a clean frame.
    run_frame(3 * H + 4, 0, -1, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_frame(H * V, 0, -1, 2'd0);

    // Long frame: extra pixels after the last one.
    run_frame(H * V, 2, -1, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    // Randomised frames with gaps, requests, clears, odd lengths.
    gaps_en = 1; rq_en = 1;
    for (int f = 0; f < 8; f++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) run_frame($urandom_range(1, H * V - 1), 0, -1, 2'd0);
      else if (kind == 1) run_frame(H * V, $urandom_range(1, 3), -1, 2'd0);
      else run_frame(H * V, 0, -1, 2'd0);
    end
    rq_en = 0; gaps_en = 0;

    // Reset asserted mid-line with a request pending.
    run_frame(H * V, 0, 2, 2'd1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, (i == 2), 2'd3, 1'b0);
    iDVAL = 1'b1;
    #2;
    iRST = 1'b0;
    #1;
    model_reset();
    chk_all(1'b1);
    iFVAL = 1'b0;
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    run_frame(H * V, 0, -1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
